// File: rtl/ft60x_bus_ctrl.sv
// rtl/ft60x_bus_ctrl.sv - FT600/FT601 synchronous 245-FIFO bus master
// Arbitrates the A2F write stream and the F2A read stream onto the shared FT60x bus.
module ft60x_bus_ctrl #(
   parameter int DATA_W    = 32,
   parameter int BE_W      = DATA_W/8,
   parameter int MAX_BURST = 256,
   parameter int ARB_MODE  = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              txe_n,
   input  logic              rxf_n,
   output logic              wr_n,
   output logic              rd_n,
   output logic              oe_n,
   output logic [DATA_W-1:0] ft_data_o,
   output logic [BE_W-1:0]   ft_be_o,
   input  logic [DATA_W-1:0] ft_data_i,
   input  logic [BE_W-1:0]   ft_be_i,
   output logic              bus_oe,
   input  logic [DATA_W-1:0] tx_data,
   input  logic [BE_W-1:0]   tx_be,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic [BE_W-1:0]   rx_be,
   output logic              rx_valid,
   input  logic              rx_afull,
   output logic [31:0]       wr_words,
   output logic [31:0]       rd_words,
   output logic              busy
);

   localparam int BCNT_W = $clog2(MAX_BURST + 1);
   localparam logic [BCNT_W-1:0] MAX_B = BCNT_W'(MAX_BURST);

   typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_TA, S_RD, S_GAP} state_t;

   state_t              state_q, state_d;
   logic                wr_n_q, wr_n_d, rd_n_q, rd_n_d, oe_n_q, oe_n_d;
   logic                bus_oe_q, bus_oe_d;
   logic [DATA_W-1:0]   ft_data_q, ft_data_d, rx_data_q, rx_data_d;
   logic [BE_W-1:0]     ft_be_q, ft_be_d, rx_be_q, rx_be_d;
   logic                rx_valid_q, rx_valid_d, pend_q, pend_d;
   logic                last_rd_q, last_rd_d;
   logic [31:0]         wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
   logic [BCNT_W-1:0]   bcnt_q, bcnt_d, bcnt_rd;
   logic                wr_fire, wr_miss, rd_fire, wr_ok, rd_ok, below_max, pick_rd;

   assign wr_fire   = ~wr_n_q & ~txe_n;
   assign wr_miss   = ~wr_n_q & txe_n;
   assign rd_fire   = ~rd_n_q & ~rxf_n;
   assign wr_ok     = ~txe_n & (tx_valid | pend_q);
   assign rd_ok     = ~rxf_n & ~rx_afull;
   assign below_max = bcnt_q < MAX_B;
   assign tx_ready  = (state_q == S_WR) & ~txe_n & ~pend_q & below_max;

   always_comb begin
      state_d    = state_q;
      wr_n_d     = 1'b1;
      rd_n_d     = 1'b1;
      oe_n_d     = oe_n_q;
      bus_oe_d   = bus_oe_q;
      ft_data_d  = ft_data_q;
      ft_be_d    = ft_be_q;
      rx_data_d  = rx_data_q;
      rx_be_d    = rx_be_q;
      rx_valid_d = 1'b0;
      pend_d     = pend_q;
      last_rd_d  = last_rd_q;
      wr_cnt_d   = wr_cnt_q;
      rd_cnt_d   = rd_cnt_q;
      bcnt_d     = bcnt_q;
      bcnt_rd    = bcnt_q + BCNT_W'(rd_fire);
      pick_rd    = 1'b0;

      // Beat completion follows the pins, independent of which state we are leaving.
      if (wr_fire) begin
         wr_cnt_d = wr_cnt_q + 32'd1;
         pend_d   = 1'b0;
      end
      if (wr_miss) pend_d = 1'b1;
      if (rd_fire) begin
         rx_data_d  = ft_data_i;
         rx_be_d    = ft_be_i;
         rx_valid_d = 1'b1;
         rd_cnt_d   = rd_cnt_q + 32'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (wr_ok && rd_ok)
               pick_rd = (ARB_MODE == 1) || ((ARB_MODE == 2) && !last_rd_q);
            else
               pick_rd = rd_ok;
            if (wr_ok || rd_ok) begin
               last_rd_d = pick_rd;
               if (pick_rd) begin
                  state_d  = S_RD_TA;
                  bus_oe_d = 1'b0;
                  oe_n_d   = 1'b0;
               end else begin
                  state_d = S_WR;
               end
            end
         end
         S_WR: begin
            if (txe_n || (!tx_valid && !pend_q) || !below_max) begin
               state_d = S_GAP;
            end else if (tx_valid && tx_ready) begin
               ft_data_d = tx_data;
               ft_be_d   = tx_be;
               wr_n_d    = 1'b0;
               bcnt_d    = bcnt_q + BCNT_W'(1);
            end else if (pend_q && wr_n_q) begin
               // Retry the held word; the bubble while it is outstanding keeps it single.
               wr_n_d = 1'b0;
               bcnt_d = bcnt_q + BCNT_W'(1);
            end
         end
         S_RD_TA: begin
            state_d = S_RD;
            if (rd_ok && below_max) rd_n_d = 1'b0;
         end
         S_RD: begin
            bcnt_d = bcnt_rd;
            if (rd_ok && (bcnt_rd < MAX_B)) begin
               rd_n_d = 1'b0;
            end else begin
               state_d = S_GAP;
               oe_n_d  = 1'b1;
            end
         end
         S_GAP: begin
            bcnt_d   = '0;
            state_d  = S_IDLE;
            bus_oe_d = 1'b1;
            oe_n_d   = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         wr_n_q     <= 1'b1;
         rd_n_q     <= 1'b1;
         oe_n_q     <= 1'b1;
         bus_oe_q   <= 1'b1;
         ft_data_q  <= '0;
         ft_be_q    <= '1;
         rx_data_q  <= '0;
         rx_be_q    <= '0;
         rx_valid_q <= 1'b0;
         pend_q     <= 1'b0;
         last_rd_q  <= 1'b1;
         wr_cnt_q   <= '0;
         rd_cnt_q   <= '0;
         bcnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         wr_n_q     <= wr_n_d;
         rd_n_q     <= rd_n_d;
         oe_n_q     <= oe_n_d;
         bus_oe_q   <= bus_oe_d;
         ft_data_q  <= ft_data_d;
         ft_be_q    <= ft_be_d;
         rx_data_q  <= rx_data_d;
         rx_be_q    <= rx_be_d;
         rx_valid_q <= rx_valid_d;
         pend_q     <= pend_d;
         last_rd_q  <= last_rd_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_cnt_q   <= rd_cnt_d;
         bcnt_q     <= bcnt_d;
      end
   end

   assign wr_n      = wr_n_q;
   assign rd_n      = rd_n_q;
   assign oe_n      = oe_n_q;
   assign bus_oe    = bus_oe_q;
   assign ft_data_o = ft_data_q;
   assign ft_be_o   = ft_be_q;
   assign rx_data   = rx_data_q;
   assign rx_be     = rx_be_q;
   assign rx_valid  = rx_valid_q;
   assign wr_words  = wr_cnt_q;
   assign rd_words  = rd_cnt_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ft60x_bus_ctrl.sv
// tb/tb_ft60x_bus_ctrl.sv - directed self-checking bench for ft60x_bus_ctrl
// Instance a: 32-bit, write priority. Instance b: 16-bit, MAX_BURST 4, round-robin.
module tb_ft60x_bus_ctrl;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        a_txe_n, a_rxf_n, a_wr_n, a_rd_n, a_oe_n, a_bus_oe;
   logic [31:0] a_ft_data_o, a_ft_data_i, a_tx_data, a_rx_data, a_wr_words, a_rd_words;
   logic [3:0]  a_ft_be_o, a_ft_be_i, a_tx_be, a_rx_be;
   logic        a_tx_valid, a_tx_ready, a_rx_valid, a_rx_afull, a_busy;

   logic        b_txe_n, b_rxf_n, b_wr_n, b_rd_n, b_oe_n, b_bus_oe;
   logic [15:0] b_ft_data_o, b_ft_data_i, b_tx_data, b_rx_data;
   logic [31:0] b_wr_words, b_rd_words;
   logic [1:0]  b_ft_be_o, b_ft_be_i, b_tx_be, b_rx_be;
   logic        b_tx_valid, b_tx_ready, b_rx_valid, b_rx_afull, b_busy;

   ft60x_bus_ctrl u_a (
      .clk(clk), .reset(reset), .txe_n(a_txe_n), .rxf_n(a_rxf_n),
      .wr_n(a_wr_n), .rd_n(a_rd_n), .oe_n(a_oe_n),
      .ft_data_o(a_ft_data_o), .ft_be_o(a_ft_be_o),
      .ft_data_i(a_ft_data_i), .ft_be_i(a_ft_be_i), .bus_oe(a_bus_oe),
      .tx_data(a_tx_data), .tx_be(a_tx_be), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
      .rx_data(a_rx_data), .rx_be(a_rx_be), .rx_valid(a_rx_valid), .rx_afull(a_rx_afull),
      .wr_words(a_wr_words), .rd_words(a_rd_words), .busy(a_busy)
   );

   ft60x_bus_ctrl #(.DATA_W(16), .MAX_BURST(4), .ARB_MODE(2)) u_b (
      .clk(clk), .reset(reset), .txe_n(b_txe_n), .rxf_n(b_rxf_n),
      .wr_n(b_wr_n), .rd_n(b_rd_n), .oe_n(b_oe_n),
      .ft_data_o(b_ft_data_o), .ft_be_o(b_ft_be_o),
      .ft_data_i(b_ft_data_i), .ft_be_i(b_ft_be_i), .bus_oe(b_bus_oe),
      .tx_data(b_tx_data), .tx_be(b_tx_be), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
      .rx_data(b_rx_data), .rx_be(b_rx_be), .rx_valid(b_rx_valid), .rx_afull(b_rx_afull),
      .wr_words(b_wr_words), .rd_words(b_rd_words), .busy(b_busy)
   );

   int tests = 0;
   int fails = 0;
   int hazards = 0;
   logic [31:0] a_wq[$];
   logic [31:0] a_rq[$];
   logic [15:0] b_wq[$];
   logic [1:0]  b_bq[$];
   int b_dir[$];
   int b_len[$];
   int cur_w = 0;
   int cur_r = 0;

   // Pin-level observers, sampled mid-cycle: what the FT chip would see at the next edge.
   always @(negedge clk) begin
      if (!reset) begin
         if (!a_wr_n && !a_txe_n) a_wq.push_back(a_ft_data_o);
         if (a_rx_valid) a_rq.push_back(a_rx_data);
         if (!b_wr_n && !b_txe_n) begin
            b_wq.push_back(b_ft_data_o);
            b_bq.push_back(b_ft_be_o);
            cur_w++;
         end
         if (!b_rd_n && !b_rxf_n) cur_r++;
         if (!b_busy && (cur_w + cur_r) > 0) begin
            b_dir.push_back((cur_w > 0) ? 0 : 1);
            b_len.push_back(cur_w + cur_r);
            cur_w = 0;
            cur_r = 0;
         end
      end
      if ((a_bus_oe && !a_oe_n) || (b_bus_oe && !b_oe_n)) hazards++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag, input bit use_b);
      int n;
      n = 0;
      while ((use_b ? b_busy : a_busy) && n < 100) begin
         tick();
         n++;
      end
      check(tag, use_b ? b_busy : a_busy, 0);
   endtask

   initial begin
      logic hs;
      logic rdhs;
      int idx, full_cnt, rd_idx, rxv, hold, paused;
      bit full_done, afull_done;
      reset = 1'b1;
      a_txe_n = 1'b1; a_rxf_n = 1'b1; a_ft_data_i = '0; a_ft_be_i = 4'hF;
      a_tx_data = '0; a_tx_be = 4'hF; a_tx_valid = 1'b0; a_rx_afull = 1'b0;
      b_txe_n = 1'b1; b_rxf_n = 1'b1; b_ft_data_i = 16'h5A5A; b_ft_be_i = 2'b11;
      b_tx_data = '0; b_tx_be = 2'b11; b_tx_valid = 1'b0; b_rx_afull = 1'b0;
      repeat (3) tick();
      reset = 1'b0;

      check("rst_wr_n", a_wr_n, 1);
      check("rst_rd_n", a_rd_n, 1);
      check("rst_oe_n", a_oe_n, 1);
      check("rst_bus_oe", a_bus_oe, 1);
      check("rst_data", a_ft_data_o, 0);
      check("rst_be", a_ft_be_o, 4'hF);
      check("rst_be16", b_ft_be_o, 2'b11);
      check("rst_rx_valid", a_rx_valid, 0);
      check("rst_wr_words", a_wr_words, 0);
      check("rst_rd_words", a_rd_words, 0);
      check("rst_busy", a_busy, 0);
      check("rst_tx_ready", a_tx_ready, 0);

      // Write burst of 10 words
      a_txe_n = 1'b0;
      idx = 0;
      for (int c = 0; c < 100 && idx < 10; c++) begin
         a_tx_data = idx + 1;
         a_tx_valid = 1'b1;
         @(negedge clk); hs = a_tx_ready;
         tick();
         if (hs) idx++;
      end
      a_tx_valid = 1'b0;
      check("wr_accepted", idx, 10);
      tick();
      check("wr_gap_busy", a_busy, 1);
      check("wr_gap_wr_n", a_wr_n, 1);
      tick();
      check("wr_idle", a_busy, 0);
      check("wr_count", a_wq.size(), 10);
      for (int i = 0; i < 10; i++) check("wr_word", a_wq[i], i + 1);
      check("wr_words", a_wr_words, 10);

      // FT full while word 5 is strobed
      a_wq.delete();
      idx = 0; full_cnt = 0; full_done = 0;
      for (int c = 0; c < 200 && idx < 10; c++) begin
         a_tx_data = idx + 1;
         a_tx_valid = 1'b1;
         @(negedge clk); hs = a_tx_ready;
         tick();
         if (hs) idx++;
         if (full_cnt > 0) begin
            full_cnt--;
            if (full_cnt == 3) begin
               check("pend_wr_n", a_wr_n, 1);
               check("pend_hold", a_ft_data_o, 5);
            end
            if (full_cnt == 0) a_txe_n = 1'b0;
         end else if (!full_done && !a_wr_n && a_ft_data_o == 32'd5) begin
            a_txe_n = 1'b1;
            full_cnt = 4;
            full_done = 1;
         end
      end
      a_tx_valid = 1'b0;
      check("full_seen", full_done, 1);
      wait_idle("full_idle", 0);
      check("full_count", a_wq.size(), 10);
      for (int i = 0; i < 10; i++) check("full_word", a_wq[i], i + 1);
      check("full_wr_words", a_wr_words, 20);

      // Read 20 words, sink backs off after the 8th
      a_txe_n = 1'b1; a_rxf_n = 1'b0; a_ft_data_i = 32'h100; a_ft_be_i = 4'hF;
      a_rq.delete();
      rd_idx = 0; rxv = 0; hold = 0; paused = 0; afull_done = 0;
      for (int c = 0; c < 400 && rxv < 20; c++) begin
         @(negedge clk); rdhs = !a_rd_n && !a_rxf_n;
         tick();
         if (a_rx_valid) rxv++;
         if (rdhs) begin
            rd_idx++;
            a_ft_data_i = 32'h100 + rd_idx;
            a_ft_be_i = (rd_idx == 19) ? 4'h3 : 4'hF;
            if (rd_idx == 20) a_rxf_n = 1'b1;
         end
         if (!afull_done && rxv >= 8) begin
            a_rx_afull = 1'b1;
            afull_done = 1;
            hold = 8;
         end else if (hold > 0) begin
            hold--;
            if (hold == 0) begin
               check("rd_pause_rd_n", a_rd_n, 1);
               paused = rxv;
               a_rx_afull = 1'b0;
            end
         end
      end
      check("rd_pause_max10", (paused <= 10 && paused >= 8), 1);
      wait_idle("rd_idle", 0);
      check("rd_count", a_rq.size(), 20);
      for (int i = 0; i < 20; i++) check("rd_word", a_rq[i], 32'h100 + i);
      check("rd_last_be", a_rx_be, 4'h3);
      check("rd_words", a_rd_words, 20);
      check("rd_bus_oe_back", a_bus_oe, 1);

      // Round-robin on the 16-bit instance, both directions always eligible
      b_txe_n = 1'b0; b_rxf_n = 1'b0; b_tx_valid = 1'b1; b_tx_be = 2'b11; b_tx_data = 16'd0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk); hs = b_tx_ready;
         tick();
         if (hs) b_tx_data = b_tx_data + 16'd1;
      end
      b_tx_valid = 1'b0; b_rxf_n = 1'b1;
      wait_idle("rr_idle", 1);
      repeat (2) tick();
      check("rr_bursts", b_dir.size() >= 4, 1);
      for (int i = 0; i < 4; i++) begin
         check("rr_dir", b_dir[i], i % 2);
         check("rr_len", b_len[i], 4);
      end
      for (int i = 0; i < 8; i++) check("rr_wdata", b_wq[i], i);
      check("hazard", hazards, 0);

      // Partial last word on the 16-bit bus
      b_wq.delete(); b_bq.delete();
      b_txe_n = 1'b0;
      idx = 0;
      for (int c = 0; c < 50 && idx < 3; c++) begin
         b_tx_data = 16'hA001 + 16'(idx);
         b_tx_be = (idx == 2) ? 2'b01 : 2'b11;
         b_tx_valid = 1'b1;
         @(negedge clk); hs = b_tx_ready;
         tick();
         if (hs) idx++;
      end
      b_tx_valid = 1'b0;
      wait_idle("be_idle", 1);
      check("be_count", b_bq.size(), 3);
      check("be_w0", b_bq[0], 2'b11);
      check("be_w1", b_bq[1], 2'b11);
      check("be_w2", b_bq[2], 2'b01);
      check("be_d2", b_wq[2], 16'hA003);

      // Reset while reading
      a_rxf_n = 1'b0; a_rx_afull = 1'b0;
      idx = 0;
      while (a_rd_n && idx < 20) begin
         tick();
         idx++;
      end
      check("rst_rd_reached", a_rd_n, 0);
      reset = 1'b1;
      tick();
      check("mrst_rd_n", a_rd_n, 1);
      check("mrst_oe_n", a_oe_n, 1);
      check("mrst_bus_oe", a_bus_oe, 1);
      check("mrst_rx_valid", a_rx_valid, 0);
      check("mrst_wr_words", a_wr_words, 0);
      check("mrst_rd_words", a_rd_words, 0);
      check("mrst_busy", a_busy, 0);
      reset = 1'b0;
      a_rxf_n = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
